// File: rtl/pir_activity_sampler.sv
// PIR front end: per-line 2-flop synchroniser and debounce, then per-sensor
// active-cycle counts over a fixed window, published with a one-cycle strobe.
module pir_activity_sampler #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WINDOW          = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] pir_raw,
  output logic [6:0] level_1,
  output logic [6:0] level_2,
  output logic [6:0] level_3,
  output logic       level_valid,
  output logic [2:0] pir_clean
);

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] W_LAST  = 7'(WINDOW - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [2:0]      sync1_q, sync2_q, clean_q;
  logic [2:0][3:0] dcnt_q;
  logic [6:0]      wcnt_q, wcnt_d;
  logic [2:0][6:0] acnt_q, acnt_d, acnt_sum;
  logic [2:0][6:0] level_q, level_d;
  logic            valid_q, valid_d;

  // Synchroniser and debounce are free-running, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      dcnt_q  <= '0;
    end else begin
      sync1_q <= pir_raw;
      sync2_q <= sync1_q;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2_q[i] == clean_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DB_LAST) begin
          clean_q[i] <= sync2_q[i];
          dcnt_q[i]  <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      acnt_q  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      acnt_q  <= acnt_d;
      level_q <= level_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      acnt_sum[i] = acnt_q[i] + {6'b0, clean_q[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    acnt_d  = acnt_q;
    level_d = level_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        wcnt_d = '0;
        acnt_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        // Dropping enable wins over a coincident window end: partial window is discarded.
        if (!enable) begin
          state_d = IDLE;
          wcnt_d  = '0;
          acnt_d  = '0;
        end else if (wcnt_q == W_LAST) begin
          level_d = acnt_sum;
          valid_d = 1'b1;
          acnt_d  = '0;
          wcnt_d  = '0;
        end else begin
          acnt_d = acnt_sum;
          wcnt_d = wcnt_q + 7'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level_1     = level_q[0];
  assign level_2     = level_q[1];
  assign level_3     = level_q[2];
  assign level_valid = valid_q;
  assign pir_clean   = clean_q;

endmodule
